// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM driving datapath selects/enables from op, zero and mem_ready.
// Latency: lw 5, sw/R-type/addi/slti 4, beq/bne/j/jal 3 cycles with mem_ready high; +1 per not-ready cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; MEM_TIMEOUT consecutive stalls trap (0 disables).
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap on unknown opcodes (default build retires them as NOPs).
module mc_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_CNT_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [5:0]           op_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 pc_write_o,
    output logic                 iord_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 ir_write_o,
    output logic                 reg_write_o,
    output logic                 alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           alu_op_o,
    output logic [1:0]           pc_src_o,
    output logic [1:0]           mem_to_reg_o,
    output logic [1:0]           reg_dst_o,
    output logic [3:0]           state_o,
    output logic                 instr_done_o,
    output logic                 trap_o,
    output logic [RET_CNT_W-1:0] ret_cnt_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_BNE    = 4'd9,
        S_ADDIEX = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_SLTIEX = 4'd14,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // The wait counter only needs to reach MEM_TIMEOUT-1: the Nth stall cycle
    // itself is detected combinationally and redirects the next state.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_e                 state_q, state_d;
    logic [5:0]             op_q, op_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [RET_CNT_W-1:0]   ret_cnt_q, ret_cnt_d;

    logic                   in_mem_state;
    logic                   mem_stall;
    logic                   timeout_hit;
    logic                   op_known;
    logic                   retire;

    // Classify the current cycle: memory-wait state, stalled, and whether the stall budget is spent.
    always_comb begin
        in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        mem_stall    = in_mem_state && !mem_ready_i;
        timeout_hit  = TIMEOUT_EN && mem_stall && (wait_q == WAIT_LAST);
    end

    // Recognise the opcodes this controller knows how to sequence.
    always_comb begin
        op_known = 1'b0;
        case (op_i)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI,
            OP_BEQ, OP_BNE, OP_J, OP_JAL: op_known = 1'b1;
            default:                      op_known = 1'b0;
        endcase
    end

    // State, latched opcode, wait counter and retire counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            wait_q    <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    // Next-state sequencing; a spent stall budget overrides the normal transition.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                // op is only valid here; MEMADR needs it one cycle later to pick lw vs sw.
                op_d = op_i;
                case (op_i)
                    OP_RTYPE:      state_d = S_RTEX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_SLTI:       state_d = S_SLTIEX;
                    OP_BEQ:        state_d = S_BEQ;
                    OP_BNE:        state_d = S_BNE;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:       state_d = S_TRAP;
`else
                    default:       state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_RTEX:   state_d = S_RTWB;
            S_ADDIEX: state_d = S_IWB;
            S_SLTIEX: state_d = S_IWB;
            S_MEMWB, S_RTWB, S_IWB,
            S_BEQ, S_BNE, S_JUMP, S_JAL: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
        if (timeout_hit) state_d = S_TRAP;
    end

    // Consecutive-stall counter: restarts on any state change or completed access.
    always_comb begin
        if (!TIMEOUT_EN || !mem_stall || (state_d != state_q)) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Retired-instruction counter, wrapping naturally at 2^RET_CNT_W.
    always_comb begin
        ret_cnt_d = ret_cnt_q;
        if (retire) ret_cnt_d = ret_cnt_q + RET_CNT_W'(1);
    end

    // Moore outputs per state; pc_write/ir_write/instr_done add their zero/mem_ready qualifiers.
    always_comb begin
        pc_write_o   = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        pc_src_o     = 2'b00;
        mem_to_reg_o = 2'b00;
        reg_dst_o    = 2'b00;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
`ifndef MC_ILLEGAL_TRAP_EN
                // Unknown opcodes retire here as a no-op.
                retire      = !op_known;
`endif
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                retire      = mem_ready_i;
            end
            S_RTEX: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            S_RTWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 2'b01;
                retire      = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = 2'b00;
            end
            S_SLTIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = 2'b11;
            end
            S_IWB: begin
                reg_write_o = 1'b1;
                retire      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_src_o    = 2'b01;
                pc_write_o  = zero_i;
                retire      = 1'b1;
            end
            S_BNE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_src_o    = 2'b01;
                pc_write_o  = !zero_i;
                retire      = 1'b1;
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
                retire     = 1'b1;
            end
            S_JAL: begin
                // Link write sees the old PC: the register file and PC load on the same edge.
                pc_write_o   = 1'b1;
                pc_src_o     = 2'b10;
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'b10;
                mem_to_reg_o = 2'b10;
                retire       = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_done_o = retire;
    assign trap_o       = (state_q == S_TRAP);
    assign state_o      = state_q;
    assign ret_cnt_o    = ret_cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction stream against an instruction-level model of the controller.
// Latency: inputs driven at negedge, outputs sampled 1ns later, one check set per cycle.
// Backpressure: memory stalls chosen per instruction; some exceed the timeout to force TRAP.
module tb_mc_controller;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic [5:0]    op_i = 6'd0;
    logic          zero_i = 1'b0;
    logic          mem_ready_i = 1'b0;
    logic          pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o, alu_src_a_o;
    logic [1:0]    alu_src_b_o, alu_op_o, pc_src_o, mem_to_reg_o, reg_dst_o;
    logic [3:0]    state_o;
    logic          instr_done_o, trap_o;
    logic [CW-1:0] ret_cnt_o;

    int chk_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;

    always #5 clk_i = ~clk_i;

    mc_controller #(.MEM_TIMEOUT(TO), .RET_CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .pc_src_o(pc_src_o),
        .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o), .state_o(state_o),
        .instr_done_o(instr_done_o), .trap_o(trap_o), .ret_cnt_o(ret_cnt_o)
    );

    typedef struct packed {
        logic       pcw, iord, mrd, mwr, irw, rw, asa;
        logic [1:0] asb, aop, psrc, m2r, rdst;
        logic       done, trap;
    } o_t;

    o_t obs;
    assign obs = {pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o, alu_src_a_o,
                  alu_src_b_o, alu_op_o, pc_src_o, mem_to_reg_o, reg_dst_o, instr_done_o, trap_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(input logic [5:0] o);
        return (o == OP_RT) || (o == OP_LW) || (o == OP_SW) || (o == OP_ADDI) || (o == OP_SLTI) ||
               (o == OP_BEQ) || (o == OP_BNE) || (o == OP_J) || (o == OP_JAL);
    endfunction

    // Expected control word for a state, from the per-state output table.
    function automatic o_t eo(input int st, input bit rdy, input bit z);
        o_t o;
        o = '0;
        case (st)
            0:  begin o.mrd = 1'b1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            1:  o.asb = 2'b11;
            2:  begin o.asa = 1'b1; o.asb = 2'b10; end
            3:  begin o.mrd = 1'b1; o.iord = 1'b1; end
            4:  begin o.rw = 1'b1; o.m2r = 2'b01; o.done = 1'b1; end
            5:  begin o.mwr = 1'b1; o.iord = 1'b1; o.done = rdy; end
            6:  begin o.asa = 1'b1; o.aop = 2'b10; end
            7:  begin o.rw = 1'b1; o.rdst = 2'b01; o.done = 1'b1; end
            8:  begin o.asa = 1'b1; o.aop = 2'b01; o.psrc = 2'b01; o.pcw = z; o.done = 1'b1; end
            9:  begin o.asa = 1'b1; o.aop = 2'b01; o.psrc = 2'b01; o.pcw = !z; o.done = 1'b1; end
            10: begin o.asa = 1'b1; o.asb = 2'b10; o.aop = 2'b00; end
            11: begin o.rw = 1'b1; o.done = 1'b1; end
            12: begin o.pcw = 1'b1; o.psrc = 2'b10; o.done = 1'b1; end
            13: begin o.pcw = 1'b1; o.psrc = 2'b10; o.rw = 1'b1; o.rdst = 2'b10; o.m2r = 2'b10; o.done = 1'b1; end
            14: begin o.asa = 1'b1; o.asb = 2'b10; o.aop = 2'b11; end
            15: o.trap = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // One clock cycle: drive, check state/outputs/count, advance to the next negedge.
    task automatic step(input int st, input logic [5:0] opv, input bit rdy, input bit z, input bit nop_done);
        o_t e;
        op_i = opv;
        zero_i = z;
        mem_ready_i = rdy;
        #1;
        e = eo(st, rdy, z);
        if (nop_done) e.done = 1'b1;
        check("state", 32'(state_o), 32'(st));
        check("outputs", 32'(obs), 32'(e));
        check("ret_cnt", 32'(ret_cnt_o), 32'(exp_cnt));
        if (e.done) exp_cnt = (exp_cnt + 1) % (1 << CW);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        op_i = rop();
        zero_i = rb();
        mem_ready_i = 1'b0;
        #1;
        exp_cnt = 0;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_outputs", 32'(obs), 32'(eo(0, 1'b0, 1'b0)));
        check("rst_ret_cnt", 32'(ret_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic trap_hold();
        for (int i = 0; i < 3; i++) step(15, rop(), rb(), rb(), 1'b0);
        do_reset();
    endtask

    // A memory-wait state with w stall cycles; w >= TO must end in TRAP.
    task automatic mem_phase(input int st, input int w, output bit trapped);
        int n;
        n = (w < TO) ? w : TO;
        for (int i = 0; i < n; i++) step(st, rop(), 1'b0, rb(), 1'b0);
        if (w >= TO) begin
            trapped = 1'b1;
            trap_hold();
        end else begin
            trapped = 1'b0;
            step(st, rop(), 1'b1, rb(), 1'b0);
        end
    endtask

    // Whole instruction: op is only presented truthfully in DECODE, garbage elsewhere.
    task automatic run_instr(input logic [5:0] opc, input int wf, input int wm, input bit bz);
        bit tr;
        mem_phase(0, wf, tr);
        if (tr) return;
        if (!legal(opc)) begin
`ifdef MC_ILLEGAL_TRAP_EN
            step(1, opc, rb(), rb(), 1'b0);
            trap_hold();
`else
            step(1, opc, rb(), rb(), 1'b1);
`endif
            return;
        end
        step(1, opc, rb(), rb(), 1'b0);
        case (opc)
            OP_LW: begin
                step(2, rop(), rb(), rb(), 1'b0);
                mem_phase(3, wm, tr);
                if (!tr) step(4, rop(), rb(), rb(), 1'b0);
            end
            OP_SW: begin
                step(2, rop(), rb(), rb(), 1'b0);
                mem_phase(5, wm, tr);
            end
            OP_RT:   begin step(6, rop(), rb(), rb(), 1'b0); step(7, rop(), rb(), rb(), 1'b0); end
            OP_ADDI: begin step(10, rop(), rb(), rb(), 1'b0); step(11, rop(), rb(), rb(), 1'b0); end
            OP_SLTI: begin step(14, rop(), rb(), rb(), 1'b0); step(11, rop(), rb(), rb(), 1'b0); end
            OP_BEQ:  step(8, rop(), rb(), bz, 1'b0);
            OP_BNE:  step(9, rop(), rb(), bz, 1'b0);
            OP_J:    step(12, rop(), rb(), rb(), 1'b0);
            OP_JAL:  step(13, rop(), rb(), rb(), 1'b0);
            default: ;
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops [9];
        logic [5:0] opc;
        int wf, wm;
        ops = '{OP_RT, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_J, OP_JAL};

        @(negedge clk_i);
        do_reset();

        // Directed: the basic instruction classes and stall patterns.
        run_instr(OP_RT, 0, 0, 1'b0);
        run_instr(OP_LW, 0, 3, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BNE, 0, 0, 1'b1);
        run_instr(OP_JAL, 0, 0, 1'b0);
        run_instr(OP_SW, 2, 1, 1'b0);
        run_instr(OP_ADDI, 1, 0, 1'b0);
        run_instr(OP_SLTI, 0, 0, 1'b0);

        // Stall boundary: ready on the last allowed cycle completes, one more traps.
        run_instr(OP_J, TO - 1, 0, 1'b0);
        run_instr(OP_J, TO, 0, 1'b0);
        run_instr(OP_LW, 0, TO - 1, 1'b0);
        run_instr(OP_LW, 0, TO, 1'b0);
        run_instr(OP_SW, 0, TO, 1'b0);

        // Unknown opcode.
        run_instr(6'b111111, 0, 0, 1'b0);

        // Reset in the middle of an R-type.
        step(0, rop(), 1'b1, rb(), 1'b0);
        step(1, OP_RT, rb(), rb(), 1'b0);
        step(6, rop(), rb(), rb(), 1'b0);
        do_reset();

        // Counter wrap.
        for (int i = 0; i < (1 << CW) + 2; i++) run_instr(OP_J, 0, 0, 1'b0);

        // Random instruction stream.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) opc = rop();
            else opc = ops[$urandom_range(0, 8)];
            wf = ($urandom_range(0, 29) == 0) ? TO : $urandom_range(0, TO - 1);
            wm = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
            run_instr(opc, wf, wm, rb());
            if ($urandom_range(0, 49) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle successor to the single-cycle MIPS main decoder: a Moore FSM that sequences each instruction over 3–5 cycles. It waits on a memory ready handshake, traps on a memory timeout, and counts retired instructions. It sits beside the shared-memory multicycle datapath and drives its mux selects and enables from `op`, `zero` and `mem_ready`.

## Interface
- `MEM_TIMEOUT`, default 16: consecutive not-ready cycles in a memory state that trigger TRAP. The value 0 disables the timeout.
- `RET_CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `op` in 6: opcode from the instruction register, sampled in DECODE only.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `pc_write` out 1: PC load enable, already qualified by `zero` and `mem_ready`.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read`, `mem_write`, `ir_write`, `reg_write` out 1 each.
- `alu_src_a` out 1: ALU A select (0 = PC, 1 = A).
- `alu_src_b` out 2: ALU B select (00 = B, 01 = 4, 10 = SignExt, 11 = SignExt<<2).
- `alu_op` out 2: 00 add, 01 sub, 10 funct, 11 slt.
- `pc_src` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `mem_to_reg` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `reg_dst` out 2: 00 rt, 01 rd, 10 $31.
- `state` out 4: current state encoding.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `trap` out 1: sticky fault indicator.
- `ret_cnt` out `RET_CNT_W`: retired-instruction count.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQ 8, BNE 9, ADDIEX 10, IWB 11, JUMP 12, JAL 13, SLTIEX 14, TRAP 15.
- Any output not listed for a state is 0.
- FETCH: `mem_read`=1, `alu_src_b`=01. `ir_write` and `pc_write` equal `mem_ready`. Move to DECODE on `mem_ready`; otherwise hold.
- DECODE: `alu_src_b`=11. Next state by `op`:
  - 000000 → RTEX
  - 100011 or 101011 → MEMADR
  - 001000 → ADDIEX
  - 001010 → SLTIEX
  - 000100 → BEQ
  - 000101 → BNE
  - 000010 → JUMP
  - 000011 → JAL
  - any other opcode: see Configuration.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Go to MEMRD for lw, MEMWR for sw, using `op` latched in DECODE.
- MEMRD: `mem_read`=1, `iord`=1. Go to MEMWB on `mem_ready`.
- MEMWB: `reg_write`=1, `mem_to_reg`=01.
- MEMWR: `mem_write`=1, `iord`=1. Retire on `mem_ready`.
- RTEX: `alu_src_a`=1, `alu_op`=10, then RTWB. RTWB: `reg_write`=1, `reg_dst`=01.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, then IWB.
- SLTIEX: same as ADDIEX but `alu_op`=11, then IWB.
- IWB: `reg_write`=1.
- BEQ and BNE: `alu_src_a`=1, `alu_op`=01, `pc_src`=01. `pc_write`=`zero` for BEQ, `!zero` for BNE.
- JUMP: `pc_write`=1, `pc_src`=10.
- JAL: `pc_write`=1, `pc_src`=10, `reg_write`=1, `reg_dst`=10, `mem_to_reg`=10. The register write uses the PC value before the jump load.
- Retiring states: MEMWB, MEMWR (when `mem_ready`), RTWB, IWB, BEQ, BNE, JUMP, JAL.
  - Each asserts `instr_done` and returns to FETCH.
  - `ret_cnt` increments on `instr_done` and wraps to 0 at 2^`RET_CNT_W`.
- Timeout:
  - A wait counter counts cycles spent in FETCH, MEMRD or MEMWR with `mem_ready`=0.
  - It clears on any state change or on `mem_ready`=1.
  - When it reaches `MEM_TIMEOUT`, the next state is TRAP and the pending access is abandoned.
- TRAP: all datapath outputs 0, `trap`=1. It is left only by reset.

## Timing
- Reset values: state=FETCH, `ret_cnt`=0, wait counter 0, `trap`=0, `instr_done`=0.
  - Because FETCH is the reset state, `mem_read`=1 and `alu_src_b`=01 during reset; every other output is 0.
- Outputs are combinational from state. `pc_write`, `ir_write` and `instr_done` are additionally qualified by `zero`/`mem_ready` as stated in Operation.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles
  - sw, R-type, addi, slti: 4 cycles
  - beq, bne, j, jal: 3 cycles
- Each not-ready cycle adds one cycle.
- `mem_ready`=1 outside a memory state is ignored.
- `rst_n` asserted mid-instruction returns to FETCH immediately. The interrupted instruction is not counted.
- With `MEM_TIMEOUT`=N, TRAP is entered in the cycle after the Nth consecutive not-ready cycle. `mem_ready` arriving in that same Nth cycle wins: the access completes and no trap occurs.

## Configuration
- Macro: `MC_ILLEGAL_TRAP_EN`.
- Defined: an unrecognised opcode in DECODE goes to TRAP and `trap` is set.
- Undefined: an unrecognised opcode is a NOP. DECODE goes to FETCH with `instr_done`=1 and `ret_cnt` increments.

## Test plan
- Reset, then R-type `op`=000000 with `mem_ready`=1 → states 0,1,6,7,0. `reg_dst`=01 in RTWB, `instr_done` pulses once, `ret_cnt`=1.
- lw with `mem_ready` low 3 cycles in MEMRD → 8 cycles total. `mem_to_reg`=01 in MEMWB, `iord`=1 throughout MEMRD.
- beq with `zero`=1 then bne with `zero`=1 → `pc_write`=1 only in BEQ. Both set `pc_src`=01. `ret_cnt` +2.
- jal → `reg_dst`=10, `mem_to_reg`=10 and `pc_write`=1 in state 13, 3 cycles total.
- `MEM_TIMEOUT`=4, `mem_ready` stuck at 0 in FETCH → state=15 after 4 cycles, `trap`=1 until `rst_n`=0. A repeat run with `mem_ready`=1 on cycle 4 reaches DECODE, no trap.
- `op`=111111: with `MC_ILLEGAL_TRAP_EN` → TRAP. Without it → FETCH after 2 cycles, `ret_cnt` +1. Counter at 2^16−1 plus one retire → 0.
